// File: rtl/card_src_if.sv
// Card source handshake: the source presents card_value with card_valid,
// and the dealer controller holds card_req high while it is ready to take a card.
interface card_src_if;
  logic       card_req;
  logic       card_valid;
  logic [3:0] card_value;

  modport master (input card_req, output card_valid, output card_value);
  modport slave  (output card_req, input card_valid, input card_value);
endinterface

// File: rtl/blackjack_dealer_ctrl.sv
// Single-hand dealer controller: draws cards into four slots, tracks the running
// sum, arbitrates hit/stand with an inactivity timeout and reports the hand result.
//
// state | meaning
// IDLE  | no hand in progress
// DRAW  | card_req high, waiting for a non-zero card
// CHECK | one-cycle evaluation of the new sum / card count
// WAIT  | waiting for hit/stand, timeout counter running
// WIN   | sum hit TARGET exactly
// BUST  | sum went over TARGET
// STOOD | player stood, timed out, or all four slots filled
module blackjack_dealer_ctrl #(
  parameter int TARGET         = 18,
  parameter int MAX_FACE       = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  card_src_if.slave  card,
  output logic [3:0] first_card,
  output logic [3:0] second_card,
  output logic [3:0] third_card,
  output logic [3:0] fourth_card,
  output logic [2:0] card_count,
  output logic [6:0] sum,
  output logic [2:0] ctrl_state,
  output logic [1:0] result,
  output logic       done
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_STOOD = 2'b01;
  localparam logic [1:0] RES_WIN   = 2'b10;
  localparam logic [1:0] RES_BUST  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAW  = 3'd1,
    CHECK = 3'd2,
    WAIT  = 3'd3,
    WIN   = 3'd4,
    BUST  = 3'd5,
    STOOD = 3'd6
  } state_t;

  state_t        state;
  logic [3:0]    slot [4];
  logic [CW-1:0] wait_cnt;
  logic [3:0]    card_clamped;

  assign card_clamped = (card.card_value > 4'(MAX_FACE)) ? 4'(MAX_FACE) : card.card_value;

  assign first_card  = slot[0];
  assign second_card = slot[1];
  assign third_card  = slot[2];
  assign fourth_card = slot[3];
  assign ctrl_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
      card_count    <= '0;
      sum           <= '0;
      result        <= RES_NONE;
      done          <= 1'b0;
      wait_cnt      <= '0;
      card.card_req <= 1'b0;
    end else begin
      case (state)
        IDLE, WIN, BUST, STOOD: begin
          if (start) begin
            for (int i = 0; i < 4; i++) slot[i] <= '0;
            card_count    <= '0;
            sum           <= '0;
            result        <= RES_NONE;
            done          <= 1'b0;
            wait_cnt      <= '0;
            card.card_req <= 1'b1;
            state         <= DRAW;
          end
        end

        DRAW: begin
          // A zero card is not a real card; keep requesting.
          if (card.card_valid && card.card_req && card.card_value != 4'd0) begin
            slot[card_count[1:0]] <= card_clamped;
            sum                   <= sum + 7'(card_clamped);
            card_count            <= card_count + 3'd1;
            card.card_req         <= 1'b0;
            state                 <= CHECK;
          end
        end

        CHECK: begin
          if (sum == 7'(TARGET)) begin
            result <= RES_WIN;
            done   <= 1'b1;
            state  <= WIN;
          end else if (sum > 7'(TARGET)) begin
            result <= RES_BUST;
            done   <= 1'b1;
            state  <= BUST;
          end else if (card_count < 3'd2) begin
            card.card_req <= 1'b1;
            state         <= DRAW;
          end else if (card_count == 3'd4) begin
            result <= RES_STOOD;
            done   <= 1'b1;
            state  <= STOOD;
          end else begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (stand) begin
            wait_cnt <= '0;
            result   <= RES_STOOD;
            done     <= 1'b1;
            state    <= STOOD;
          end else if (hit) begin
            wait_cnt      <= '0;
            card.card_req <= 1'b1;
            state         <= DRAW;
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            wait_cnt <= '0;
            result   <= RES_STOOD;
            done     <= 1'b1;
            state    <= STOOD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          card.card_req <= 1'b0;
          done          <= 1'b0;
          wait_cnt      <= '0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blackjack_dealer_ctrl.sv
// Randomized hands against a transaction-level model of the game rules,
// plus directed cases for the deal, clamp, timeout and reset corners.
module tb_blackjack_dealer_ctrl;
  localparam int TO = 8;

  localparam int S_IDLE  = 0;
  localparam int S_DRAW  = 1;
  localparam int S_CHECK = 2;
  localparam int S_WAIT  = 3;
  localparam int S_WIN   = 4;
  localparam int S_BUST  = 5;
  localparam int S_STOOD = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       stand = 1'b0;
  logic [3:0] first_card, second_card, third_card, fourth_card;
  logic [2:0] card_count;
  logic [6:0] sum;
  logic [2:0] ctrl_state;
  logic [1:0] result;
  logic       done;

  card_src_if cif ();

  blackjack_dealer_ctrl #(.TARGET(18), .MAX_FACE(10), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .hit         (hit),
    .stand       (stand),
    .card        (cif),
    .first_card  (first_card),
    .second_card (second_card),
    .third_card  (third_card),
    .fourth_card (fourth_card),
    .card_count  (card_count),
    .sum         (sum),
    .ctrl_state  (ctrl_state),
    .result      (result),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mcards[$];
  int msum;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampv(int v);
    return (v > 10) ? 10 : v;
  endfunction

  // Where the hand goes after a card has been added, from the game rules.
  function automatic int outcome();
    if (msum == 18) return S_WIN;
    if (msum > 18) return S_BUST;
    if (mcards.size() < 2) return S_DRAW;
    if (mcards.size() == 4) return S_STOOD;
    return S_WAIT;
  endfunction

  function automatic int exp_result(int st);
    case (st)
      S_WIN:   return 2;
      S_BUST:  return 3;
      S_STOOD: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int slot_out(int i);
    case (i)
      0: return int'(first_card);
      1: return int'(second_card);
      2: return int'(third_card);
      default: return int'(fourth_card);
    endcase
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    mcards.delete();
    msum = 0;
    check("start_state", ctrl_state, S_DRAW);
    check("start_req", cif.card_req, 1);
    check("start_count", card_count, 0);
    check("start_sum", sum, 0);
    check("start_slot0", first_card, 0);
    check("start_slot3", fourth_card, 0);
    check("start_done", done, 0);
    check("start_result", result, 0);
  endtask

  task automatic deal(input int v);
    int n = 0;
    int exp;
    while (!cif.card_req && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("req_wait", cif.card_req, 1);
    cif.card_valid = 1'b1;
    cif.card_value = 4'(v);
    tick();
    cif.card_valid = 1'b0;
    cif.card_value = 4'd0;
    if (v == 0) begin
      check("zero_state", ctrl_state, S_DRAW);
      check("zero_req", cif.card_req, 1);
      check("zero_count", card_count, mcards.size());
      check("zero_sum", sum, msum);
    end else begin
      mcards.push_back(clampv(v));
      msum += clampv(v);
      check("slot_val", slot_out(mcards.size() - 1), clampv(v));
      check("sum", sum, msum);
      check("count", card_count, mcards.size());
      check("check_state", ctrl_state, S_CHECK);
      check("check_req", cif.card_req, 0);
      tick();
      exp = outcome();
      check("post_state", ctrl_state, exp);
      check("post_req", cif.card_req, (exp == S_DRAW) ? 1 : 0);
      check("post_done", done, (exp >= S_WIN) ? 1 : 0);
      check("post_result", result, exp_result(exp));
    end
  endtask

  // kind: 0 hit, 1 stand, 2 hit+stand, 3 let the timeout fire
  task automatic wait_act(input int pause, input int kind, input bit poke_start);
    int n;
    for (int i = 0; i < pause; i++) begin
      start = poke_start && (i == 0);
      tick();
      start = 1'b0;
    end
    check("pause_state", ctrl_state, S_WAIT);
    check("pause_sum", sum, msum);
    case (kind)
      0: begin
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("hit_state", ctrl_state, S_DRAW);
        check("hit_req", cif.card_req, 1);
      end
      1, 2: begin
        stand = 1'b1;
        hit = (kind == 2);
        tick();
        stand = 1'b0;
        hit = 1'b0;
        check("stand_state", ctrl_state, S_STOOD);
        check("stand_result", result, 1);
        check("stand_done", done, 1);
        check("stand_req", cif.card_req, 0);
      end
      default: begin
        n = pause;
        while (ctrl_state == 3'(S_WAIT) && n < 40) begin
          tick();
          n++;
        end
        check("timeout_len", n, TO);
        check("timeout_state", ctrl_state, S_STOOD);
        check("timeout_result", result, 1);
      end
    endcase
  endtask

  task automatic terminal_hold();
    int st = int'(ctrl_state);
    hit = 1'b1;
    stand = 1'b1;
    tick();
    tick();
    hit = 1'b0;
    stand = 1'b0;
    check("term_hold_state", ctrl_state, st);
    check("term_hold_sum", sum, msum);
    check("term_hold_req", cif.card_req, 0);
    check("term_hold_result", result, exp_result(st));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    cif.card_valid = 1'b0;
    cif.card_value = 4'd0;
    #1;
    check("rst_state", ctrl_state, S_IDLE);
    check("rst_req", cif.card_req, 0);
    check("rst_sum", sum, 0);
    check("rst_done", done, 0);
    #22 rst = 1'b1;
    tick();
    tick();
    check("idle_state", ctrl_state, S_IDLE);

    // Two-card deal to exactly 18
    do_start();
    deal(10);
    deal(8);
    check("win_slot1", second_card, 8);
    check("win_slot2", third_card, 0);
    terminal_hold();

    // Hit to bust
    do_start();
    deal(9);
    deal(5);
    wait_act(0, 0, 1'b0);
    deal(7);
    check("bust_slot3", fourth_card, 0);

    // Zero rejected, 13 clamped
    do_start();
    deal(0);
    deal(13);
    deal(4);
    check("clamp_first", first_card, 10);
    wait_act(2, 1, 1'b1);

    // Hit and stand together
    do_start();
    deal(5);
    deal(7);
    wait_act(0, 2, 1'b0);

    // Timeout
    do_start();
    deal(3);
    deal(4);
    wait_act(0, 3, 1'b0);

    // Four small cards fill every slot
    do_start();
    deal(2);
    deal(2);
    wait_act(3, 0, 1'b1);
    deal(2);
    wait_act(0, 0, 1'b0);
    deal(2);
    check("four_sum", sum, 8);

    // Async reset mid-DRAW; card_valid during reset is dropped
    do_start();
    deal(6);
    #2 rst = 1'b0;
    #1;
    check("async_state", ctrl_state, S_IDLE);
    check("async_slot0", first_card, 0);
    check("async_count", card_count, 0);
    check("async_sum", sum, 0);
    check("async_req", cif.card_req, 0);
    cif.card_valid = 1'b1;
    cif.card_value = 4'd5;
    tick();
    tick();
    cif.card_valid = 1'b0;
    cif.card_value = 4'd0;
    #2 rst = 1'b1;
    tick();
    check("post_rst_count", card_count, 0);
    check("post_rst_state", ctrl_state, S_IDLE);

    // Random hands
    for (int h = 0; h < 40; h++) begin
      do_start();
      guard = 0;
      while (guard < 30) begin
        guard++;
        if (ctrl_state == 3'(S_DRAW))
          deal($urandom_range(0, 15));
        else if (ctrl_state == 3'(S_WAIT))
          wait_act($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        else
          break;
      end
      check("rand_done", done, 1);
      terminal_hold();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
